// File: rtl/bus_arb_pkg.sv
// Shared types and bus widths for the round-robin bus master arbiter.
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bus_master_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] rot;
  logic            found;

  always_comb begin
    // Rotate so the slot after ptr lands at bit 0, scan upward, then map back.
    rot   = NREQ'({req, req} >> (32'(ptr) + 32'd1));
    idx   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        idx   = IW'((32'(ptr) + 32'd1 + j) % NREQ);
      end
    end
    grant = found ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter driving one shared master bus from NREQ requesters.
// Optional BUSY watchdog with abort pulse: define BUS_ARB_TIMEOUT_EN.
module bus_master_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          grant,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic                     wen,
  output logic                     ren,
  output logic [$clog2(NREQ)-1:0]  valid,
  input  logic                     ready
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("bus_master_arbiter: NREQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IW-1:0]       valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                finish;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          abort;

  assign abort   = (state_q == BUSY) && !ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout = to_q;
`else
  logic          abort;
  assign abort = 1'b0;
`endif

  assign finish = ready || abort;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    ack_d   = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = BUSY;
          grant_d = pick_grant;
          valid_d = pick_idx;
          wen_d   = req_wen[pick_idx];
          ren_d   = !req_wen[pick_idx];
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
              addr_d = req_addr[i*ADDR_W +: ADDR_W];
              data_d = req_data[i*DATA_W +: DATA_W];
            end
          end
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (finish) begin
          state_d = DONE;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          grant_d = '0;
          valid_d = '0;
          ack_d   = grant_q;
          ptr_d   = valid_q;
`ifdef BUS_ARB_TIMEOUT_EN
          to_d    = abort;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      grant_q <= '0;
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ack_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      ack_q   <= ack_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign req_ack = ack_q;
  assign grant   = grant_q;
  assign valid   = valid_q;
  assign addr    = addr_q;
  assign data    = data_q;
  assign wen     = wen_q;
  assign ren     = ren_q;

endmodule
